// File: rtl/cache_axi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cache_axi_bridge_pkg
// Brief   : Shared FSM encodings and fixed AXI attributes for the cache bridge.
// Revision: 1.0
// ============================================================================
package cache_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR      = 3'd3,
        ST_WR_RESP = 3'd4
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam logic [7:0] c_AXI_LEN        = 8'd0;
    localparam logic [1:0] c_AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] c_AXI_ID         = 4'd0;

    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_axi_bridge_strb_gen.sv
`default_nettype none
// ============================================================================
// Module  : cache_axi_bridge_strb_gen
// Brief   : Byte-lane write strobe from transfer size and address offset.
// Revision: 1.0
// ============================================================================
module cache_axi_bridge_strb_gen (
    input  logic [1:0] i_size,
    input  logic [1:0] i_addr_lo,
    output logic [3:0] o_wstrb
);

    always_comb begin
        o_wstrb = 4'b1111;
        case (i_size)
            2'd0:    o_wstrb = 4'b0001 << i_addr_lo;
            2'd1:    o_wstrb = 4'b0011 << i_addr_lo;
            default: o_wstrb = 4'b1111;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cache_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module  : cache_axi_bridge
// Brief   : Arbitrates inst/data cache ports onto a single-beat AXI master,
//           one transaction outstanding at a time.
// Revision: 1.0
// ============================================================================
module cache_axi_bridge
    import cache_axi_bridge_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,

    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    output logic        wlast,
    input  logic        wready,

    input  logic        bvalid,
    output logic        bready
);

    state_t      r_state;
    owner_t      r_owner;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_arvalid;
    logic        r_rready;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_bready;
    logic        r_aw_done;
    logic        r_w_done;
    logic        r_inst_data_ok;
    logic        r_data_data_ok;
    logic [31:0] r_inst_rdata;
    logic [31:0] r_data_rdata;

    logic        w_idle_free;
    logic        w_grant_inst;
    logic        w_grant_data;
    logic        w_grant;
    logic        w_req_wr;
    logic [1:0]  w_req_size;
    logic [31:0] w_req_addr;
    logic [31:0] w_req_wdata;
    logic        w_aw_fire;
    logic        w_w_fire;
    logic        w_aw_done_now;
    logic        w_w_done_now;

    // Grants are held off during the data_ok cycle so the next grant lands
    // on the cycle after data_ok, and never while reset is asserted.
    assign w_idle_free  = (r_state == ST_IDLE) && !r_inst_data_ok && !r_data_data_ok && !rst;
    assign w_grant_data = w_idle_free && data_req && (DATA_FIRST || !inst_req);
    assign w_grant_inst = w_idle_free && inst_req && (!DATA_FIRST || !data_req);
    assign w_grant      = w_grant_data || w_grant_inst;

    assign w_req_wr    = w_grant_data ? data_wr    : inst_wr;
    assign w_req_size  = w_grant_data ? data_size  : inst_size;
    assign w_req_addr  = w_grant_data ? data_addr  : inst_addr;
    assign w_req_wdata = w_grant_data ? data_wdata : inst_wdata;

    assign w_aw_fire     = r_awvalid && awready;
    assign w_w_fire      = r_wvalid && wready;
    assign w_aw_done_now = r_aw_done || w_aw_fire;
    assign w_w_done_now  = r_w_done || w_w_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_owner        <= OWN_INST;
            r_size         <= 2'd0;
            r_addr         <= 32'd0;
            r_wdata        <= 32'd0;
            r_arvalid      <= 1'b0;
            r_rready       <= 1'b0;
            r_awvalid      <= 1'b0;
            r_wvalid       <= 1'b0;
            r_bready       <= 1'b0;
            r_aw_done      <= 1'b0;
            r_w_done       <= 1'b0;
            r_inst_data_ok <= 1'b0;
            r_data_data_ok <= 1'b0;
            r_inst_rdata   <= 32'd0;
            r_data_rdata   <= 32'd0;
        end else begin
            r_inst_data_ok <= 1'b0;
            r_data_data_ok <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_grant_data ? OWN_DATA : OWN_INST;
                        r_size  <= w_req_size;
                        r_addr  <= w_req_addr;
                        r_wdata <= w_req_wdata;
                        if (w_req_wr) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= ST_WR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (r_arvalid && arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rvalid) begin
                        r_rready <= 1'b0;
                        if (r_owner == OWN_DATA) begin
                            r_data_rdata   <= rdata;
                            r_data_data_ok <= 1'b1;
                        end else begin
                            r_inst_rdata   <= rdata;
                            r_inst_data_ok <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                ST_WR: begin
                    if (w_aw_fire) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_fire) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_done_now && w_w_done_now) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_bready  <= 1'b1;
                        r_state   <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (bvalid) begin
                        r_bready <= 1'b0;
                        if (r_owner == OWN_DATA) begin
                            r_data_data_ok <= 1'b1;
                        end else begin
                            r_inst_data_ok <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    cache_axi_bridge_strb_gen u_strb_gen (
        .i_size    (r_size),
        .i_addr_lo (r_addr[1:0]),
        .o_wstrb   (wstrb)
    );

    assign inst_addr_ok = w_grant_inst;
    assign data_addr_ok = w_grant_data;
    assign inst_data_ok = r_inst_data_ok;
    assign data_data_ok = r_data_data_ok;
    assign inst_rdata   = r_inst_rdata;
    assign data_rdata   = r_data_rdata;

    assign arid    = c_AXI_ID;
    assign araddr  = r_addr;
    assign arlen   = c_AXI_LEN;
    assign arsize  = axi_size(r_size);
    assign arburst = c_AXI_BURST_INCR;
    assign arvalid = r_arvalid;
    assign rready  = r_rready;

    assign awid    = c_AXI_ID;
    assign awaddr  = r_addr;
    assign awlen   = c_AXI_LEN;
    assign awsize  = axi_size(r_size);
    assign awburst = c_AXI_BURST_INCR;
    assign awvalid = r_awvalid;

    assign wdata   = r_wdata;
    assign wvalid  = r_wvalid;
    assign wlast   = r_wvalid;
    assign bready  = r_bready;

endmodule
`default_nettype wire

// File: tb/tb_cache_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_cache_axi_bridge
// Brief   : Self-checking bench: vector table, corner sequences, random traffic.
// Revision: 1.0
// ============================================================================
module tb_cache_axi_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        arready, rvalid, awready, wready, bvalid;
    logic [31:0] rdata;

    // DATA_FIRST=1 instance
    logic [31:0] inst_rdata, data_rdata, araddr, awaddr, wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [3:0]  arid, awid, wstrb;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        arvalid, rready, awvalid, wvalid, wlast, bready;

    // DATA_FIRST=0 instance
    logic [31:0] inst_rdata_n, data_rdata_n, araddr_n, awaddr_n, wdata_n;
    logic        inst_addr_ok_n, inst_data_ok_n, data_addr_ok_n, data_data_ok_n;
    logic [3:0]  arid_n, awid_n, wstrb_n;
    logic [7:0]  arlen_n, awlen_n;
    logic [2:0]  arsize_n, awsize_n;
    logic [1:0]  arburst_n, awburst_n;
    logic        arvalid_n, rready_n, awvalid_n, wvalid_n, wlast_n, bready_n;

    cache_axi_bridge #(.DATA_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid),
        .wlast(wlast), .wready(wready), .bvalid(bvalid), .bready(bready)
    );

    cache_axi_bridge #(.DATA_FIRST(1'b0)) dut_n (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_rdata(inst_rdata_n), .inst_addr_ok(inst_addr_ok_n), .inst_data_ok(inst_data_ok_n),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata_n), .data_addr_ok(data_addr_ok_n), .data_data_ok(data_data_ok_n),
        .arid(arid_n), .araddr(araddr_n), .arlen(arlen_n), .arsize(arsize_n), .arburst(arburst_n),
        .arvalid(arvalid_n), .arready(arready), .rdata(rdata), .rvalid(rvalid), .rready(rready_n),
        .awid(awid_n), .awaddr(awaddr_n), .awlen(awlen_n), .awsize(awsize_n), .awburst(awburst_n),
        .awvalid(awvalid_n), .awready(awready), .wdata(wdata_n), .wstrb(wstrb_n), .wvalid(wvalid_n),
        .wlast(wlast_n), .wready(wready), .bvalid(bvalid), .bready(bready_n)
    );

    typedef struct {
        bit          port;      // 1 = data port, 0 = inst port
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        int          ar_d, r_d, aw_d, w_d, b_d;
        logic [3:0]  strb;      // expected write strobe
    } txn_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_rdata [2];   // last read data seen per port: [0]=inst, [1]=data
    txn_t        vec [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Byte-lane model: the low 'bytes' lanes shifted up by the address offset.
    function automatic logic [3:0] ref_strb(input logic [1:0] size, input logic [1:0] off);
        int nbytes;
        int mask;
        nbytes = 1 << size;
        mask   = (1 << nbytes) - 1;
        return 4'((mask << off) & 15);
    endfunction

    function automatic txn_t mk(input bit port, input bit wr, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdat, input logic [31:0] rdat,
                                input int ar_d, input int r_d, input int aw_d, input int w_d, input int b_d,
                                input logic [3:0] strb);
        txn_t t;
        t.port = port; t.wr = wr; t.size = size; t.addr = addr; t.wdat = wdat; t.rdat = rdat;
        t.ar_d = ar_d; t.r_d = r_d; t.aw_d = aw_d; t.w_d = w_d; t.b_d = b_d; t.strb = strb;
        return t;
    endfunction

    task automatic set_req(input txn_t t, input bit on);
        if (t.port) begin
            data_req = on; data_wr = t.wr; data_size = t.size; data_addr = t.addr; data_wdata = t.wdat;
        end else begin
            inst_req = on; inst_wr = t.wr; inst_size = t.size; inst_addr = t.addr; inst_wdata = t.wdat;
        end
    endtask

    // Starts and ends on a falling edge; returns at the data_ok cycle.
    task automatic run_txn(input txn_t t, output int waited);
        int nv_aw, nv_w, last;
        set_req(t, 1'b1);
        waited = -1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (t.port ? data_addr_ok : inst_addr_ok) begin
                waited = c;
                break;
            end
            @(negedge clk);
        end
        if (waited < 0) begin
            chk("addr_ok_timeout", 32'd0, 32'd1);
            set_req(t, 1'b0);
            return;
        end
        @(negedge clk);
        set_req(t, 1'b0);
        if (!t.wr) begin
            chk("arvalid", {31'd0, arvalid}, 32'd1);
            chk("araddr", araddr, t.addr);
            chk("arsize", {29'd0, arsize}, {30'd0, t.size});
            chk("ar_fixed", {18'd0, arid, arlen, arburst}, 32'h0000_0001);
            repeat (t.ar_d) @(negedge clk);
            arready = 1'b1;
            @(negedge clk);
            arready = 1'b0;
            chk("ar_done_rready", {30'd0, arvalid, rready}, 32'd1);
            repeat (t.r_d) @(negedge clk);
            rvalid = 1'b1;
            rdata  = t.rdat;
            @(negedge clk);
            rvalid = 1'b0;
            rdata  = $urandom;
            m_rdata[t.port] = t.rdat;
        end else begin
            chk("aw_w_valid_wlast", {29'd0, awvalid, wvalid, wlast}, 32'd7);
            chk("awaddr", awaddr, t.addr);
            chk("awsize", {29'd0, awsize}, {30'd0, t.size});
            chk("wdata", wdata, t.wdat);
            chk("wstrb", {28'd0, wstrb}, {28'd0, t.strb});
            chk("aw_fixed", {18'd0, awid, awlen, awburst}, 32'h0000_0001);
            nv_aw = 0;
            nv_w  = 0;
            last  = (t.aw_d > t.w_d) ? t.aw_d : t.w_d;
            for (int c = 0; c <= last; c++) begin
                if (awvalid) nv_aw++;
                if (wvalid) nv_w++;
                awready = (c == t.aw_d);
                wready  = (c == t.w_d);
                @(negedge clk);
            end
            awready = 1'b0;
            wready  = 1'b0;
            chk("awvalid_cycles", nv_aw, t.aw_d + 1);
            chk("wvalid_cycles", nv_w, t.w_d + 1);
            chk("wr_resp_entry", {29'd0, awvalid, wvalid, bready}, 32'd1);
            repeat (t.b_d) @(negedge clk);
            bvalid = 1'b1;
            @(negedge clk);
            bvalid = 1'b0;
        end
        chk("data_ok_owner", {30'd0, inst_data_ok, data_data_ok}, t.port ? 32'd1 : 32'd2);
        chk("ready_drop", {30'd0, rready, bready}, 32'd0);
        chk("inst_rdata", inst_rdata, m_rdata[0]);
        chk("data_rdata", data_rdata, m_rdata[1]);
    endtask

    initial begin
        int   w;
        txn_t t;
        rst = 1'b1;
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = 32'd0; inst_wdata = 32'd0;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        m_rdata[0] = 32'd0;
        m_rdata[1] = 32'd0;

        vec[0] = mk(1'b1, 1'b0, 2'd2, 32'h1FC0_0010, 32'h0,         32'hDEAD_BEEF, 0, 1, 0, 0, 0, 4'b0000);
        vec[1] = mk(1'b1, 1'b1, 2'd0, 32'h8000_0003, 32'hAB00_0000, 32'h0,         0, 0, 0, 2, 1, 4'b1000);
        vec[2] = mk(1'b1, 1'b1, 2'd2, 32'h0000_1000, 32'h1234_5678, 32'h0,         0, 0, 1, 1, 0, 4'b1111);
        vec[3] = mk(1'b0, 1'b0, 2'd1, 32'hBFC0_0002, 32'h0,         32'hCAFE_F00D, 2, 0, 0, 0, 0, 4'b0000);
        vec[4] = mk(1'b0, 1'b1, 2'd1, 32'h0000_0012, 32'h5555_AAAA, 32'h0,         0, 0, 2, 0, 2, 4'b1100);
        vec[5] = mk(1'b1, 1'b1, 2'd0, 32'h0000_0101, 32'h0000_7700, 32'h0,         0, 0, 1, 3, 0, 4'b0010);
        vec[6] = mk(1'b0, 1'b1, 2'd0, 32'h0000_0000, 32'h0000_0042, 32'h0,         0, 0, 3, 3, 1, 4'b0001);
        vec[7] = mk(1'b1, 1'b1, 2'd1, 32'h0000_0004, 32'h0000_BEEF, 32'h0,         0, 0, 0, 0, 0, 4'b0011);

        // Reset state, with both requests held high
        @(negedge clk);
        #1;
        chk("reset_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        chk("reset_valids", {25'd0, arvalid, rready, awvalid, wvalid, bready, inst_data_ok, data_data_ok}, 32'd0);
        chk("reset_rdata", inst_rdata | data_rdata, 32'd0);
        inst_req = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Simultaneous requests: data wins with DATA_FIRST=1, inst with DATA_FIRST=0
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h0000_1000;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_2000;
        #1;
        chk("arb_df1_grant", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
        chk("arb_df0_grant", {30'd0, inst_addr_ok_n, data_addr_ok_n}, 32'd2);
        @(negedge clk);
        data_req = 1'b0;
        chk("arb_df1_araddr", araddr, 32'h0000_2000);
        chk("arb_df0_araddr", araddr_n, 32'h0000_1000);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'h1111_2222;
        @(negedge clk);
        rvalid = 1'b0;
        m_rdata[1] = 32'h1111_2222;
        #1;
        chk("arb_df1_data_first", {29'd0, data_data_ok, inst_addr_ok, inst_data_ok}, 32'd4);
        chk("arb_df1_data_rdata", data_rdata, 32'h1111_2222);
        chk("arb_df0_inst_first", {30'd0, inst_data_ok_n, data_data_ok_n}, 32'd2);
        @(negedge clk);
        #1;
        chk("arb_df1_inst_after", {31'd0, inst_addr_ok}, 32'd1);
        @(negedge clk);
        inst_req = 1'b0;
        chk("arb_df1_inst_araddr", araddr, 32'h0000_1000);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'h3333_4444;
        @(negedge clk);
        rvalid = 1'b0;
        m_rdata[0] = 32'h3333_4444;
        chk("arb_df1_inst_rdata", inst_rdata, 32'h3333_4444);
        @(negedge clk);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            run_txn(vec[i], w);
            @(negedge clk);
            chk("data_ok_single", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        end

        // Halfword write at offset 2 followed by a back-to-back read
        run_txn(mk(1'b1, 1'b1, 2'd1, 32'h0000_0022, 32'hAAAA_0000, 32'h0, 0, 0, 1, 0, 0, 4'b1100), w);
        run_txn(mk(1'b1, 1'b0, 2'd2, 32'h0000_0030, 32'h0, 32'h0BAD_CAFE, 0, 0, 0, 0, 0, 4'b0000), w);
        chk("b2b_grant_delay", w, 32'd1);
        @(negedge clk);

        // Reset while waiting in the read-data phase
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_0040;
        @(negedge clk);
        data_req = 1'b0;
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk("pre_reset_rready", {31'd0, rready}, 32'd1);
        rst    = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'h5A5A_5A5A;
        data_req = 1'b1;
        #1;
        chk("midreset_signals", {25'd0, arvalid, rready, awvalid, wvalid, bready, inst_data_ok, data_data_ok}, 32'd0);
        chk("midreset_addr_ok", {31'd0, data_addr_ok}, 32'd0);
        chk("midreset_rdata", inst_rdata | data_rdata, 32'd0);
        m_rdata[0] = 32'd0;
        m_rdata[1] = 32'd0;
        @(negedge clk);
        rst      = 1'b0;
        rvalid   = 1'b0;
        data_req = 1'b0;
        #1;
        chk("postreset_no_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        @(negedge clk);
        run_txn(mk(1'b0, 1'b0, 2'd2, 32'h0000_0080, 32'h0, 32'h7777_8888, 1, 1, 0, 0, 0, 4'b0000), w);
        chk("postreset_grant_delay", w, 32'd0);
        @(negedge clk);

        // Random traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            t.port = 1'($urandom_range(0, 1));
            t.wr   = 1'($urandom_range(0, 1));
            t.size = 2'($urandom_range(0, 2));
            t.addr = $urandom;
            if (t.size == 2'd1) t.addr[0] = 1'b0;
            if (t.size == 2'd2) t.addr[1:0] = 2'b00;
            t.wdat = $urandom;
            t.rdat = $urandom;
            t.ar_d = $urandom_range(0, 3);
            t.r_d  = $urandom_range(0, 3);
            t.aw_d = $urandom_range(0, 3);
            t.w_d  = $urandom_range(0, 3);
            t.b_d  = $urandom_range(0, 3);
            t.strb = ref_strb(t.size, t.addr[1:0]);
            run_txn(t, w);
            @(negedge clk);
            chk("rand_data_ok_single", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
